// File: rtl/register_file.sv
// Two-read, one-write register file (32 x 32 by default) with register 0 hardwired to zero.
// Reads are combinational; the single write port commits on the rising clock edge.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_address_0,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] write_address_0,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data_0,
  output logic [DATA_WIDTH-1:0] read_data_1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is never stored; index 0 decodes to a constant zero on both read ports.
  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en && (write_address_0 != '0)) begin
      regs[write_address_0] <= write_data;
    end
  end

  always_comb begin
    read_data_0 = '0;
    if (read_address_0 != '0) begin
      read_data_0 = regs[read_address_0];
    end
  end

  always_comb begin
    read_data_1 = '0;
    if (read_address_1 != '0) begin
      read_data_1 = regs[read_address_1];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset clearing, write/read, write disable,
// register 0 protection, read-during-write ordering and reset priority.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read_address_0;
  logic [4:0]  read_address_1;
  logic [4:0]  write_address_0;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data_0;
  logic [31:0] read_data_1;

  int checks = 0;
  int failures = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_address_0  (read_address_0),
    .read_address_1  (read_address_1),
    .write_address_0 (write_address_0),
    .write_en        (write_en),
    .write_data      (write_data),
    .read_data_0     (read_data_0),
    .read_data_1     (read_data_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle a little before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    write_en = 1'b1;
    write_address_0 = a;
    write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  // Reads every register through both ports and checks it against the expected image.
  task automatic sweep(input string tag, input logic [31:0] img [32]);
    for (int i = 0; i < 32; i++) begin
      read_address_0 = 5'(i);
      read_address_1 = 5'(31 - i);
      #1;
      check($sformatf("%s_p0_r%0d", tag, i), read_data_0, img[i]);
      check($sformatf("%s_p1_r%0d", tag, 31 - i), read_data_1, img[31 - i]);
    end
  endtask

  logic [31:0] zeros [32];
  logic [31:0] pattern [32];

  initial begin
    rst = 1'b0;
    write_en = 1'b0;
    write_address_0 = '0;
    write_data = '0;
    read_address_0 = '0;
    read_address_1 = '0;
    for (int i = 0; i < 32; i++) zeros[i] = '0;

    // Register 0 reads zero even before any reset.
    #2;
    check("pre_reset_r0", read_data_0, 32'h0);

    // Reset then read
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    read_address_0 = 5'd10;
    read_address_1 = 5'd15;
    #1;
    check("reset_r10", read_data_0, 32'h0);
    check("reset_r15", read_data_1, 32'h0);
    sweep("after_reset", zeros);

    // Basic write/read
    @(negedge clk);
    write_reg(5'd17, 32'd420);
    write_reg(5'd18, 32'd670);
    read_address_0 = 5'd17;
    read_address_1 = 5'd18;
    #1;
    check("basic_r17", read_data_0, 32'd420);
    check("basic_r18", read_data_1, 32'd670);

    // Write disabled for several edges
    write_en = 1'b0;
    write_address_0 = 5'd17;
    write_data = 32'hDEADBEEF;
    repeat (4) tick();
    check("wdis_r17", read_data_0, 32'd420);
    check("wdis_r18", read_data_1, 32'd670);

    // Register 0 protection
    @(negedge clk);
    write_reg(5'd0, 32'hFFFFFFFF);
    read_address_0 = 5'd0;
    read_address_1 = 5'd0;
    #1;
    check("r0_prot_p0", read_data_0, 32'h0);
    check("r0_prot_p1", read_data_1, 32'h0);

    // Read-during-write: old value before the edge, new after
    @(negedge clk);
    write_reg(5'd5, 32'd7);
    @(negedge clk);
    read_address_0 = 5'd5;
    write_en = 1'b1;
    write_address_0 = 5'd5;
    write_data = 32'd9;
    #1;
    check("rdw_before", read_data_0, 32'd7);
    tick();
    write_en = 1'b0;
    read_address_1 = 5'd5;
    #1;
    check("rdw_after_p0", read_data_0, 32'd9);
    check("rdw_after_p1", read_data_1, 32'd9);

    // Fill every register with a distinct pattern and verify all of them
    @(negedge clk);
    pattern[0] = '0;
    for (int i = 1; i < 32; i++) begin
      pattern[i] = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      write_reg(5'(i), pattern[i]);
    end
    sweep("pattern", pattern);

    // Reset priority over a simultaneous write, held for two cycles
    @(negedge clk);
    rst = 1'b1;
    write_en = 1'b1;
    write_address_0 = 5'd3;
    write_data = 32'd55;
    tick();
    read_address_0 = 5'd3;
    #1;
    check("rst_prio_r3", read_data_0, 32'h0);
    write_address_0 = 5'd4;
    write_data = 32'd66;
    tick();
    rst = 1'b0;
    write_en = 1'b0;
    sweep("rst_prio", zeros);

    // Writes resume on the first edge with rst low
    @(negedge clk);
    write_reg(5'd3, 32'd55);
    read_address_0 = 5'd3;
    read_address_1 = 5'd4;
    #1;
    check("resume_r3", read_data_0, 32'd55);
    check("resume_r4", read_data_1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
